// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-wide RAM port sequencer.
package mem_ctrl_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_IO_WAIT} state_e;
    typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

    localparam logic [1:0] LEN_B     = 2'b00;
    localparam logic [1:0] LEN_H     = 2'b01;
    localparam logic [1:0] LEN_W     = 2'b11;
    localparam logic [1:0] IO_HI_DEF = 2'b11;

    // Fetches are always a word; the unused LS code 2'b10 also falls through to a word.
    function automatic logic [2:0] beats(logic is_ls, logic [1:0] len);
        if (!is_ls) return 3'd4;
        case (len)
            LEN_B:   return 3'd1;
            LEN_H:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] byte_of(logic [31:0] w, logic [1:0] idx);
        return 8'(w >> {idx, 3'b000});
    endfunction
endpackage

// File: rtl/mem_ctrl_arb.sv
// Two-way round-robin grant between fetch and load/store, with the last-grant flop.
module mem_ctrl_arb
    import mem_ctrl_pkg::*;
(
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic en_in,
    input  logic if_req_in,
    input  logic ls_req_in,
    output logic gnt_vld,
    output logic gnt_ls
);
    owner_e last_q, last_d;

    always_comb begin
        gnt_vld = en_in && (if_req_in || ls_req_in);
        gnt_ls  = (if_req_in && ls_req_in) ? (last_q == OWN_IF) : ls_req_in;
        last_d  = last_q;
        if (gnt_vld) last_d = gnt_ls ? OWN_LS : OWN_IF;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) last_q <= OWN_IF;
        else           last_q <= last_d;
    end
endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide RAM port sequencer for IF/LS: splits accesses into little-endian beats.
// Optional IO_STALL_EN: IO-window stores wait while the UART TX buffer is full.
module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int         ADDR_W = 32,
    parameter logic [1:0] IO_HI  = IO_HI_DEF
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              rdy_in,
    input  logic              clear_in,
    input  logic              io_buffer_full_in,
    input  logic [7:0]        mem_din,
    output logic [7:0]        mem_dout,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_wr,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [31:0]       if_data,
    input  logic              ls_req,
    input  logic              ls_wr,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [1:0]        ls_len,
    input  logic [31:0]       ls_wdata,
    output logic              ls_done,
    output logic [31:0]       ls_rdata
);
    state_e            state_q, state_d;
    owner_e            own_q, own_d;
    logic [ADDR_W-1:0] base_q, base_d, mem_a_q, mem_a_d;
    logic [2:0]        n_q, n_d, iss_q, iss_d, cap_q, cap_d;
    logic              rd_vld_q, rd_vld_d, infl_q, infl_d;
    logic [31:0]       acc_q, acc_d, wdata_q, wdata_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d, if_done_q, if_done_d, ls_done_q, ls_done_d;
    logic [31:0]       if_data_q, if_data_d, ls_rdata_q, ls_rdata_d;
    logic              if_ok, ls_ok, arb_en, gnt_vld, gnt_ls, io_wait;

    // Stores are committed and survive a flush; reads are dropped by it.
    assign if_ok  = if_req && !if_done_q && !clear_in;
    assign ls_ok  = ls_req && !ls_done_q && (ls_wr || !clear_in);
    assign arb_en = (state_q == ST_IDLE) && rdy_in;

`ifdef IO_STALL_EN
    assign io_wait = (ls_addr[17:16] == IO_HI) && io_buffer_full_in;
`else
    logic io_unused;
    assign io_unused = io_buffer_full_in ^ (ls_addr[17:16] == IO_HI);
    assign io_wait   = 1'b0;
`endif

    mem_ctrl_arb u_arb (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .en_in     (arb_en),
        .if_req_in (if_ok),
        .ls_req_in (ls_ok),
        .gnt_vld   (gnt_vld),
        .gnt_ls    (gnt_ls)
    );

    always_comb begin
        state_d    = state_q;
        own_d      = own_q;
        base_d     = base_q;
        n_d        = n_q;
        iss_d      = iss_q;
        cap_d      = cap_q;
        rd_vld_d   = rd_vld_q;
        infl_d     = 1'b0;
        acc_d      = acc_q;
        wdata_d    = wdata_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = 1'b0;
        if_done_d  = 1'b0;
        ls_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_rdata_d = ls_rdata_q;
        case (state_q)
            ST_IDLE: if (gnt_vld) begin
                own_d   = gnt_ls ? OWN_LS : OWN_IF;
                base_d  = gnt_ls ? ls_addr : if_addr;
                n_d     = beats(gnt_ls, ls_len);
                wdata_d = ls_wdata;
                acc_d   = '0;
                cap_d   = '0;
                iss_d   = 3'd1;
                if (gnt_ls && ls_wr) begin
                    if (io_wait) state_d = ST_IO_WAIT;
                    else begin
                        state_d    = ST_WRITE;
                        mem_a_d    = ls_addr;
                        mem_dout_d = ls_wdata[7:0];
                        mem_wr_d   = 1'b1;
                    end
                end else begin
                    state_d  = ST_READ;
                    mem_a_d  = base_d;
                    rd_vld_d = 1'b1;
                end
            end
            ST_READ: begin
                if (clear_in) begin
                    state_d  = ST_IDLE;
                    rd_vld_d = 1'b0;
                end else if (!rdy_in) begin
                    // Whatever is in flight is lost; point back at the oldest missing byte.
                    mem_a_d  = base_q + ADDR_W'(cap_q);
                    iss_d    = cap_q + 3'd1;
                    rd_vld_d = 1'b1;
                end else begin
                    infl_d   = rd_vld_q;
                    rd_vld_d = 1'b0;
                    if (iss_q < n_q) begin
                        mem_a_d  = base_q + ADDR_W'(iss_q);
                        iss_d    = iss_q + 3'd1;
                        rd_vld_d = 1'b1;
                    end
                    if (infl_q) begin
                        acc_d = acc_q | ({24'd0, mem_din} << {cap_q[1:0], 3'b000});
                        cap_d = cap_q + 3'd1;
                        if (cap_d == n_q) begin
                            state_d  = ST_IDLE;
                            infl_d   = 1'b0;
                            rd_vld_d = 1'b0;
                            if (own_q == OWN_IF) begin
                                if_done_d = 1'b1;
                                if_data_d = acc_d;
                            end else begin
                                ls_done_d  = 1'b1;
                                ls_rdata_d = acc_d;
                            end
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (!rdy_in) begin
                    mem_wr_d = mem_wr_q;
                end else if (iss_q < n_q) begin
                    mem_a_d    = base_q + ADDR_W'(iss_q);
                    mem_dout_d = byte_of(wdata_q, iss_q[1:0]);
                    mem_wr_d   = 1'b1;
                    iss_d      = iss_q + 3'd1;
                end else begin
                    state_d   = ST_IDLE;
                    ls_done_d = 1'b1;
                end
            end
            ST_IO_WAIT: begin
                if (rdy_in && !io_buffer_full_in) begin
                    state_d    = ST_WRITE;
                    mem_a_d    = base_q;
                    mem_dout_d = wdata_q[7:0];
                    mem_wr_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= ST_IDLE;
            own_q      <= OWN_IF;
            base_q     <= '0;
            n_q        <= '0;
            iss_q      <= '0;
            cap_q      <= '0;
            rd_vld_q   <= 1'b0;
            infl_q     <= 1'b0;
            acc_q      <= '0;
            wdata_q    <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_data_q  <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            own_q      <= own_d;
            base_q     <= base_d;
            n_q        <= n_d;
            iss_q      <= iss_d;
            cap_q      <= cap_d;
            rd_vld_q   <= rd_vld_d;
            infl_q     <= infl_d;
            acc_q      <= acc_d;
            wdata_q    <= wdata_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            ls_done_q  <= ls_done_d;
            if_data_q  <= if_data_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    // A frozen cycle must never write, so the strobe is gated by rdy_in directly.
    assign mem_wr   = mem_wr_q & rdy_in;
    assign mem_a    = mem_a_q;
    assign mem_dout = mem_dout_q;
    assign if_done  = if_done_q;
    assign if_data  = if_data_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: byte RAM model, per-requester expected-data queues.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;
    localparam int ADDR_W = 32;

    typedef struct packed {logic st; logic [31:0] d;} exp_t;

    logic clk = 1'b0, rst_n, rdy, clr, io_full;
    logic [7:0] mem_din, mem_dout;
    logic [ADDR_W-1:0] mem_a, if_addr, ls_addr;
    logic mem_wr, if_req, if_done, ls_req, ls_wr, ls_done;
    logic [31:0] if_data, ls_wdata, ls_rdata;
    logic [1:0] ls_len;
    logic pl_en;
    logic [16:0] pl_a;
    logic [7:0] pl_d;
    logic [7:0] ram [0:(1<<17)-1];
    exp_t if_q[$], ls_q[$];
    exp_t ie, le;
    int n_cmp = 0, n_err = 0, wr_cnt = 0, if_n = 0, ls_n = 0;
    int w0, n0, wc;
    int ls_t[$], if_t[$];
    logic [31:0] ld_a [3] = '{32'h5001, 32'h5002, 32'h5000};
    logic [1:0]  ld_l [3] = '{2'b00, 2'b01, 2'b10};
    logic [31:0] ld_e [3] = '{32'h0000_00BB, 32'h0000_DDCC, 32'hDDCC_BBAA};
    int          ld_c [3] = '{3, 4, 6};
    logic [7:0] eb;

    always #5 clk = ~clk;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy), .clear_in(clr),
        .io_buffer_full_in(io_full), .mem_din(mem_din), .mem_dout(mem_dout),
        .mem_a(mem_a), .mem_wr(mem_wr), .if_req(if_req), .if_addr(if_addr),
        .if_done(if_done), .if_data(if_data), .ls_req(ls_req), .ls_wr(ls_wr),
        .ls_addr(ls_addr), .ls_len(ls_len), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata)
    );

    // Synchronous byte RAM with one-cycle read latency.
    always @(posedge clk) begin
        if (pl_en) ram[pl_a] <= pl_d;
        else if (mem_wr) begin
            ram[mem_a[16:0]] <= mem_dout;
            wr_cnt <= wr_cnt + 1;
        end
        mem_din <= ram[mem_a[16:0]];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [16:0] a, input logic [7:0] d);
        pl_en = 1'b1; pl_a = a; pl_d = d;
        step();
        pl_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (if_done) begin
            if_n++;
            if (if_q.size() == 0) chk("if_unexpected_done", if_done, 0);
            else begin
                ie = if_q.pop_front();
                chk("if_data", if_data, ie.d);
            end
        end
        if (ls_done) begin
            ls_n++;
            if (ls_q.size() == 0) chk("ls_unexpected_done", ls_done, 0);
            else begin
                le = ls_q.pop_front();
                if (!le.st) chk("ls_rdata", ls_rdata, le.d);
            end
        end
    end

    initial begin
        rst_n = 1'b1; rdy = 1'b1; clr = 1'b0; io_full = 1'b0; pl_en = 1'b0; pl_a = '0; pl_d = '0;
        if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_wr = 1'b0; ls_addr = '0; ls_len = '0; ls_wdata = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wr", mem_wr, 0);
        chk("rst_mem_dout", mem_dout, 0);
        chk("rst_done", {if_done, ls_done}, 0);
        chk("rst_data", {if_data, ls_rdata}, 0);
        step();
        rst_n = 1'b1;
        preload(17'h01000, 8'h13); preload(17'h01001, 8'h05);
        preload(17'h01002, 8'h00); preload(17'h01003, 8'h00);
        preload(17'h03000, 8'h01); preload(17'h03001, 8'h02);
        preload(17'h03002, 8'h03); preload(17'h03003, 8'h04);
        preload(17'h05000, 8'hAA); preload(17'h05001, 8'hBB);
        preload(17'h05002, 8'hCC); preload(17'h05003, 8'hDD);
        preload(17'h02004, 8'h77);

        // Word fetch: beats in cycles 1-4, done in cycle 6.
        if_q.push_back('{st: 1'b0, d: 32'h0000_0513});
        if_addr = 32'h1000; if_req = 1'b1;
        step();
        if_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 4) begin
                chk("if_mem_a", mem_a, 32'h1000 + 32'(c - 1));
                chk("if_mem_wr", mem_wr, 0);
            end
            chk("if_done_cycle", if_done, c == 6);
            step();
        end

        // Round robin with last grant IF: LS, IF, LS, IF.
        repeat (2) ls_q.push_back('{st: 1'b0, d: 32'h0403_0201});
        repeat (2) if_q.push_back('{st: 1'b0, d: 32'h0000_0513});
        ls_addr = 32'h3000; ls_len = LEN_W; ls_wr = 1'b0; ls_req = 1'b1;
        if_addr = 32'h1000; if_req = 1'b1;
        step();
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (ls_done) ls_t.push_back(c);
            if (if_done) if_t.push_back(c);
            step();
            if (ls_t.size() >= 2) ls_req = 1'b0;
            if (if_t.size() >= 2) if_req = 1'b0;
        end
        ls_req = 1'b0; if_req = 1'b0;
        chk("arb_ls_count", ls_t.size(), 2);
        chk("arb_if_count", if_t.size(), 2);
        while (ls_t.size() < 2) ls_t.push_back(0);
        while (if_t.size() < 2) if_t.push_back(0);
        chk("arb_ls0", ls_t[0], 6);
        chk("arb_if0", if_t[0], 12);
        chk("arb_ls1", ls_t[1], 18);
        chk("arb_if1", if_t[1], 24);

        // Half-word store: two beats, done in cycle 3, nothing past the end.
        ls_q.push_back('{st: 1'b1, d: 32'h0});
        w0 = wr_cnt;
        ls_addr = 32'h2002; ls_len = LEN_H; ls_wr = 1'b1; ls_wdata = 32'h0000_BEEF; ls_req = 1'b1;
        step();
        ls_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            eb = (c == 1) ? 8'hEF : 8'hBE;
            if (c <= 2) begin
                chk("st_mem_a", mem_a, 32'h2002 + 32'(c - 1));
                chk("st_mem_dout", mem_dout, eb);
                chk("st_mem_wr", mem_wr, 1);
            end else chk("st_wr_done_cycle", mem_wr, 0);
            chk("st_done_cycle", ls_done, c == 3);
            step();
        end
        step();
        chk("st_ram", {ram[17'h02004], ram[17'h02003], ram[17'h02002]}, 24'h77BEEF);
        chk("st_wr_count", wr_cnt - w0, 2);

        // Loads of each size, zero-extended; len 2'b10 behaves as a word.
        for (int i = 0; i < 3; i++) begin
            ls_q.push_back('{st: 1'b0, d: ld_e[i]});
            ls_addr = ld_a[i]; ls_len = ld_l[i]; ls_wr = 1'b0; ls_req = 1'b1;
            step();
            ls_req = 1'b0;
            for (int c = 1; c <= 7; c++) begin
                @(negedge clk);
                chk("ld_done_cycle", ls_done, c == ld_c[i]);
                step();
            end
        end

        // Flush mid fetch: no done, address stops advancing.
        n0 = if_n;
        if_addr = 32'h1000; if_req = 1'b1;
        step();
        if_req = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            clr = (c == 3);
            @(negedge clk);
            if (c == 4 || c == 7) chk("clr_mem_a_hold", mem_a, 32'h1002);
            step();
        end
        clr = 1'b0;
        chk("clr_if_no_done", if_n - n0, 0);

        // Flush during a store: the store completes.
        ls_q.push_back('{st: 1'b1, d: 32'h0});
        ls_addr = 32'h4000; ls_len = LEN_W; ls_wr = 1'b1; ls_wdata = 32'h1122_3344; ls_req = 1'b1;
        step();
        ls_req = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            clr = (c == 3);
            @(negedge clk);
            chk("clr_st_done_cycle", ls_done, c == 5);
            step();
        end
        clr = 1'b0;
        chk("clr_st_ram", {ram[17'h04003], ram[17'h04002], ram[17'h04001], ram[17'h04000]}, 32'h1122_3344);

        // Flush on the accept edge cancels a fetch grant.
        n0 = if_n;
        if_addr = 32'h1000; if_req = 1'b1; clr = 1'b1;
        step();
        if_req = 1'b0; clr = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) chk("clr_accept_mem_a", mem_a, 32'h4003);
            step();
        end
        chk("clr_accept_no_done", if_n - n0, 0);

        // Freeze in cycles 2-4 of a word load: done moves from cycle 6 to 10.
        ls_q.push_back('{st: 1'b0, d: 32'hDDCC_BBAA});
        ls_addr = 32'h5000; ls_len = LEN_W; ls_wr = 1'b0; ls_req = 1'b1;
        step();
        ls_req = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            rdy = !(c >= 2 && c <= 4);
            @(negedge clk);
            chk("stall_ld_done_cycle", ls_done, c == 10);
            chk("stall_ld_mem_wr", mem_wr, 0);
            step();
        end
        rdy = 1'b1;

        // Freeze on the first store beat: the beat is replayed.
        ls_q.push_back('{st: 1'b1, d: 32'h0});
        w0 = wr_cnt;
        ls_addr = 32'h6000; ls_len = LEN_H; ls_wr = 1'b1; ls_wdata = 32'h0000_5AA5; ls_req = 1'b1;
        step();
        ls_req = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            rdy = (c != 1);
            @(negedge clk);
            chk("stall_st_mem_wr", mem_wr, c == 2 || c == 3);
            chk("stall_st_done_cycle", ls_done, c == 4);
            step();
        end
        rdy = 1'b1;
        chk("stall_st_ram", {ram[17'h06001], ram[17'h06000]}, 16'h5AA5);
        chk("stall_st_wr_count", wr_cnt - w0, 2);

        // IO-window store with the TX buffer full for five cycles.
`ifdef IO_STALL_EN
        wc = 6;
`else
        wc = 1;
`endif
        ls_q.push_back('{st: 1'b1, d: 32'h0});
        w0 = wr_cnt;
        ls_addr = 32'h0003_0000; ls_len = LEN_B; ls_wr = 1'b1; ls_wdata = 32'h41; ls_req = 1'b1; io_full = 1'b1;
        step();
        ls_req = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            io_full = (c <= 4);
            @(negedge clk);
            chk("io_mem_wr", mem_wr, c == wc);
            chk("io_done_cycle", ls_done, c == wc + 1);
            step();
        end
        io_full = 1'b0;
        chk("io_wr_count", wr_cnt - w0, 1);
        chk("io_ram", ram[17'h10000], 8'h41);

        // Reset in the middle of a store: strobe drops at once, no done afterwards.
        w0 = wr_cnt; n0 = ls_n;
        ls_addr = 32'h7000; ls_len = LEN_W; ls_wr = 1'b1; ls_wdata = 32'hCAFE_F00D; ls_req = 1'b1;
        step();
        ls_req = 1'b0;
        @(negedge clk);
        chk("rstmid_beat0_wr", mem_wr, 1);
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_async_wr", mem_wr, 0);
        chk("rstmid_mem_a", mem_a, 0);
        step();
        rst_n = 1'b1;
        repeat (6) step();
        chk("rstmid_wr_count", wr_cnt - w0, 1);
        chk("rstmid_no_done", ls_n - n0, 0);

        chk("if_queue_drained", if_q.size(), 0);
        chk("ls_queue_drained", ls_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
